// File: rtl/mem_write_arbiter.sv
// Shared data-memory write port arbiter: CPU stores vs. buffered PS/2 keycodes,
// with a starvation guard that forces a keyboard slot under sustained stores.
module mem_write_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int KB_DEPTH   = 4,
  parameter int KB_ADDR    = 10,
  parameter int STARVE_MAX = 8
) (
  input  logic                        clk,
  input  logic                        rstin,
  input  logic                        cpu_we,
  input  logic [AW-1:0]               cpu_addr,
  input  logic [DW-1:0]               cpu_wd,
  output logic                        cpu_stall,
  input  logic                        kb_valid,
  input  logic [7:0]                  kb_code,
  output logic                        mem_we,
  output logic [AW-1:0]               mem_addr,
  output logic [DW-1:0]               mem_wd,
  output logic                        mem_src,
  output logic [$clog2(KB_DEPTH):0]   kb_count,
  output logic                        kb_full,
  output logic [7:0]                  kb_drops
);

  localparam int PW = $clog2(KB_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic {S_CPU, S_KB} state_t;

  state_t          state;
  logic [SW-1:0]   starve;
  logic [7:0]      fifo [KB_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            kb_valid_q;
  logic            armed;
  logic            push;
  logic            push_ok;
  logic            grant_cpu;
  logic            grant_kb;
  logic            kb_ne;
  logic [7:0]      head;

  // Grant selection, edge detect and FIFO accept decision
  always_comb begin
    kb_ne     = (kb_count != '0);
    grant_cpu = (state == S_CPU) & cpu_we;
    grant_kb  = ~grant_cpu & kb_ne;
    cpu_stall = (state == S_KB) & cpu_we;
    // A kb_valid level already high when reset releases is not a new event:
    // pushes are only considered once one edge has sampled kb_valid_q.
    push      = armed & kb_valid & ~kb_valid_q;
    push_ok   = push & (~kb_full | grant_kb);
    head      = fifo[rd_ptr];
  end

  assign kb_full = (kb_count == CW'(KB_DEPTH));

  // Keycode storage (contents need no reset; pointers qualify them)
  always_ff @(posedge clk) begin
    if (push_ok) fifo[wr_ptr] <= kb_code;
  end

  // FIFO pointers, occupancy, drop counter and kb_valid edge history
  always_ff @(posedge clk or negedge rstin) begin
    if (!rstin) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      kb_count   <= '0;
      kb_drops   <= '0;
      kb_valid_q <= 1'b0;
      armed      <= 1'b0;
    end else begin
      kb_valid_q <= kb_valid;
      armed      <= 1'b1;
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (grant_kb) rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, grant_kb})
        2'b10:   kb_count <= kb_count + CW'(1);
        2'b01:   kb_count <= kb_count - CW'(1);
        default: kb_count <= kb_count;
      endcase
      if (push && !push_ok && kb_drops != 8'hFF) kb_drops <= kb_drops + 8'd1;
    end
  end

  // Arbitration FSM with registered memory write port
  always_ff @(posedge clk or negedge rstin) begin
    if (!rstin) begin
      state    <= S_CPU;
      starve   <= '0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_wd   <= '0;
      mem_src  <= 1'b0;
    end else begin
      case (state)
        S_CPU: begin
          if (grant_cpu && kb_ne) begin
            starve <= starve + SW'(1);
            if (starve == SW'(STARVE_MAX - 1)) state <= S_KB;
          end else begin
            starve <= '0;
          end
        end
        S_KB: begin
          starve <= '0;
          state  <= S_CPU;
        end
        default: begin
          starve <= '0;
          state  <= S_CPU;
        end
      endcase

      mem_we <= grant_cpu | grant_kb;
      if (grant_cpu) begin
        mem_addr <= cpu_addr;
        mem_wd   <= cpu_wd;
        mem_src  <= 1'b0;
      end else if (grant_kb) begin
        mem_addr <= AW'(KB_ADDR);
        mem_wd   <= DW'(head);
        mem_src  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_write_arbiter.sv
// Randomized and directed bench for mem_write_arbiter against a queue-based
// behavioural model of the arbitration rules.
module tb_mem_write_arbiter;

  localparam int AW         = 32;
  localparam int DW         = 32;
  localparam int DEPTH      = 4;
  localparam int KB_ADDR    = 10;
  localparam int STARVE_MAX = 8;

  logic          clk = 1'b0;
  logic          rstin;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wd;
  logic          cpu_stall;
  logic          kb_valid;
  logic [7:0]    kb_code;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wd;
  logic          mem_src;
  logic [2:0]    kb_count;
  logic          kb_full;
  logic [7:0]    kb_drops;

  mem_write_arbiter #(
    .AW(AW), .DW(DW), .KB_DEPTH(DEPTH), .KB_ADDR(KB_ADDR), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rstin(rstin),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd), .cpu_stall(cpu_stall),
    .kb_valid(kb_valid), .kb_code(kb_code),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_src(mem_src),
    .kb_count(kb_count), .kb_full(kb_full), .kb_drops(kb_drops)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0]  q[$];
  int          m_starve;
  bit          m_forced;
  int          m_drops;
  bit          m_prev_v;
  bit          m_armed;
  logic        e_we;
  logic [31:0] e_addr;
  logic [31:0] e_wd;
  logic        e_src;

  logic [31:0] cur_addr;
  logic [31:0] cur_wd;
  bit          last_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("mem_we",   32'(mem_we),   32'(e_we));
    check("mem_addr", mem_addr,      e_addr);
    check("mem_wd",   mem_wd,        e_wd);
    check("mem_src",  32'(mem_src),  32'(e_src));
    check("kb_count", 32'(kb_count), 32'(q.size()));
    check("kb_full",  32'(kb_full),  32'(q.size() == DEPTH));
    check("kb_drops", 32'(kb_drops), 32'(m_drops));
  endtask

  function automatic void model_reset();
    q.delete();
    m_starve = 0;
    m_forced = 0;
    m_drops  = 0;
    m_prev_v = 0;
    m_armed  = 0;
    e_we     = 0;
    e_addr   = '0;
    e_wd     = '0;
    e_src    = 0;
    last_stall = 0;
  endfunction

  // One clock cycle: apply inputs, check the stall, predict, clock, compare.
  // Called at posedge+1.
  task automatic step(input bit we, input bit kv, input logic [7:0] kc);
    bit         g_cpu;
    bit         g_kb;
    int         sz;
    logic [7:0] h;
    cpu_we   = we;
    cpu_addr = cur_addr;
    cpu_wd   = cur_wd;
    kb_valid = kv;
    kb_code  = kc;
    #1;
    sz    = q.size();
    g_cpu = !m_forced && we;
    g_kb  = !g_cpu && sz > 0;
    check("cpu_stall", 32'(cpu_stall), 32'(m_forced && we));
    last_stall = m_forced && we;

    e_we = g_cpu || g_kb;
    if (g_cpu) begin
      e_addr = cur_addr; e_wd = cur_wd; e_src = 0;
    end else if (g_kb) begin
      h = q.pop_front();
      e_addr = KB_ADDR; e_wd = {24'd0, h}; e_src = 1;
    end
    if (m_armed && kv && !m_prev_v) begin
      if (q.size() < DEPTH) q.push_back(kc);
      else if (m_drops < 255) m_drops++;
    end
    m_prev_v = kv;
    m_armed  = 1;

    if (m_forced) begin
      m_forced = 0;
      m_starve = 0;
    end else if (g_cpu && sz > 0) begin
      m_starve++;
      if (m_starve == STARVE_MAX) m_forced = 1;
    end else begin
      m_starve = 0;
    end

    @(posedge clk); #1;
    check_outputs();
    if (g_cpu) begin
      cur_addr = $urandom;
      cur_wd   = $urandom;
    end
  endtask

  // Asynchronous reset pulse with kb_valid held at kv; called at posedge+1
  task automatic do_reset(input bit kv);
    rstin    = 1'b0;
    cpu_we   = 1'b1;
    kb_valid = kv;
    #2;
    model_reset();
    check("rst_stall", 32'(cpu_stall), 32'd0);
    check_outputs();
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_mem_we", 32'(mem_we), 32'd0);
    rstin = 1'b1;
  endtask

  initial begin
    bit kv;
    bit we;
    int guard;
    rstin = 1'b0; cpu_we = 0; cpu_addr = '0; cpu_wd = '0; kb_valid = 1'b1; kb_code = 8'h00;
    cur_addr = 32'h20; cur_wd = 32'h3FF;
    @(posedge clk); #1;
    do_reset(1'b1);

    // kb_valid held high across reset release: no event until it re-rises
    for (int i = 0; i < 3; i++) step(0, 1, 8'h55);
    step(0, 0, 8'h00);

    // Single CPU store
    cur_addr = 32'h20; cur_wd = 32'h3FF;
    step(1, 0, 8'h00);
    for (int i = 0; i < 3; i++) step(0, 0, 8'h00);

    // Single keycode with the CPU idle
    step(0, 1, 8'h1C);
    for (int i = 0; i < 4; i++) step(0, 0, 8'h00);

    // Continuous stores plus one keycode: starvation guard
    step(1, 1, 8'h2A);
    for (int i = 0; i < 14; i++) step(1, 0, 8'h00);
    for (int i = 0; i < 3; i++) step(0, 0, 8'h00);

    // Five keycodes under saturating stores: one dropped, four drain in order
    for (int k = 1; k <= 5; k++) begin
      step(1, 1, 8'(k));
      step(1, 0, 8'h00);
    end
    for (int i = 0; i < 6; i++) step(1, 0, 8'h00);
    for (int i = 0; i < 8; i++) step(0, 0, 8'h00);

    // Reset while the FIFO holds three codes and the forced slot is next
    step(1, 1, 8'hA1); step(1, 0, 8'h00);
    step(1, 1, 8'hA2); step(1, 0, 8'h00);
    step(1, 1, 8'hA3); step(1, 0, 8'h00);
    guard = 0;
    while (!m_forced && guard < 20) begin
      step(1, 0, 8'h00);
      guard++;
    end
    check("reach_skb", 32'(m_forced), 32'd1);
    check("skb_count", 32'(kb_count), 32'd3);
    do_reset(1'b0);
    for (int i = 0; i < 6; i++) step(0, 0, 8'h00);

    // Randomized traffic with occasional asynchronous resets
    kv = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset(kv);
      end else begin
        we = last_stall ? 1'b1 : ($urandom_range(0, 99) < 70);
        if ($urandom_range(0, 2) == 0) kv = ~kv;
        step(we, kv, 8'($urandom));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
